// File: rtl/latch_arb_pkg.sv
// Shared types, default parameters and the round-robin pick function
// used by the latch write arbiter and its picker.
package latch_arb_pkg;

  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_NLAT  = 4;

  // Widest requester vector the pick function handles (NREQ is 2..8).
  localparam int MAX_NREQ = 8;
  localparam int MAX_PW   = 3;

  // Write sequencer: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [MAX_PW-1:0] idx;
  } pick_t;

  // Rotating-priority search starting at ptr and wrapping modulo nreq.
  // The loop runs from the farthest offset down so the nearest request
  // to ptr is the last one written, and therefore the winner.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] req,
                                    input logic [MAX_PW-1:0]   ptr,
                                    input int                  nreq);
    pick_t p;
    int    j;
    p = '0;
    for (int i = MAX_NREQ - 1; i >= 0; i--) begin
      if (i < nreq) begin
        j = (int'(ptr) + i) % nreq;
        if (req[j[MAX_PW-1:0]]) begin
          p.valid = 1'b1;
          p.idx   = j[MAX_PW-1:0];
        end
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: one-hot winner among the
// active requests, searching upward from the pointer.
module rr_arbiter
  import latch_arb_pkg::*;
#(
  parameter  int NREQ = DEF_NREQ,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] winner_o,
  output logic            valid_o
);

  pick_t pick;

  // Zero-extend into the package function and decode its index to one-hot.
  always_comb begin
    pick     = rr_pick(MAX_NREQ'(req_i), MAX_PW'(ptr_i), NREQ);
    valid_o  = pick.valid;
    winner_o = '0;
    if (pick.valid) winner_o[pick.idx[PW-1:0]] = 1'b1;
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin write arbiter in front of a bank of level-sensitive latches.
// Each write is sequenced as setup / enable pulse / hold so D is stable for
// a full cycle on both sides of the EN pulse. Every output is a flop; the
// asynchronous reset drops EN immediately, even mid-pulse.
module latch_write_arbiter
  import latch_arb_pkg::*;
#(
  parameter  int NREQ  = DEF_NREQ,
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NLAT  = DEF_NLAT,
  localparam int AW    = (NLAT > 1) ? $clog2(NLAT) : 1,
  localparam int PW    = $clog2(NREQ)
) (
  input  logic                  CLK,
  input  logic                  R,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*AW-1:0]    ADDR,
  input  logic [NREQ*WIDTH-1:0] WDATA,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       ACK,
  output logic                  ERR,
  output logic                  BUSY,
  output logic [WIDTH-1:0]      D,
  output logic [NLAT-1:0]       EN,
  output state_t                STATE_DBG
);

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    widx_q, widx_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic [NLAT-1:0]  en_q, en_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  logic [NREQ-1:0]  winner;
  logic             win_valid;
  logic [PW-1:0]    win_idx;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic             addr_ok;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (REQ),
    .ptr_i   (ptr_q),
    .winner_o(winner),
    .valid_o (win_valid)
  );

  // Encode the winner and select its address/data for capture.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (winner[i]) win_idx = PW'(i);
    end
    sel_addr = ADDR[win_idx*AW +: AW];
    sel_data = WDATA[win_idx*WIDTH +: WIDTH];
    addr_ok  = 32'(addr_q) < NLAT;
  end

  // State and datapath registers; reset clears EN without waiting for CLK.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      widx_q  <= '0;
      addr_q  <= '0;
      d_q     <= '0;
      gnt_q   <= '0;
      ack_q   <= '0;
      en_q    <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      d_q     <= d_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      en_q    <= en_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state: only IDLE waits; the other states always advance.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (win_valid) state_d = SETUP;
      SETUP: state_d = PULSE;
      PULSE: state_d = HOLD;
      HOLD:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs: each value is computed for the state being entered.
  always_comb begin
    ptr_d  = ptr_q;
    widx_d = widx_q;
    addr_d = addr_q;
    d_d    = d_q;
    gnt_d  = gnt_q;
    ack_d  = '0;
    en_d   = '0;
    err_d  = 1'b0;
    busy_d = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          widx_d = win_idx;
          addr_d = sel_addr;
          d_d    = sel_data;
          gnt_d  = winner;
        end
      end
      SETUP: begin
        for (int i = 0; i < NLAT; i++) begin
          en_d[i] = addr_ok && (32'(addr_q) == i);
        end
      end
      PULSE: begin
        ack_d = gnt_q;
        err_d = !addr_ok;
      end
      HOLD: begin
        gnt_d = '0;
        ptr_d = (32'(widx_q) == NREQ - 1) ? '0 : widx_q + PW'(1);
      end
      default: ;
    endcase
  end

  assign GNT       = gnt_q;
  assign ACK       = ack_q;
  assign ERR       = err_q;
  assign BUSY      = busy_q;
  assign D         = d_q;
  assign EN        = en_q;
  assign STATE_DBG = state_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench: a 4-latch instance and a 3-latch instance share stimulus;
// a latch-bank model sits on each so written values can be read back.
module tb_latch_write_arbiter;
  import latch_arb_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int AW    = 2;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic R   = 1'b0;
  always #5 CLK = ~CLK;

  logic [NREQ-1:0]       REQ   = '0;
  logic [NREQ*AW-1:0]    ADDR  = '0;
  logic [NREQ*WIDTH-1:0] WDATA = '0;

  logic [NREQ-1:0]  gnt4, ack4, gnt3, ack3;
  logic             err4, busy4, err3, busy3;
  logic [WIDTH-1:0] d4, d3;
  logic [3:0]       en4;
  logic [2:0]       en3;
  state_t           st4, st3;

  latch_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NLAT(4)) dut4 (
    .CLK(CLK), .R(R), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA),
    .GNT(gnt4), .ACK(ack4), .ERR(err4), .BUSY(busy4), .D(d4), .EN(en4),
    .STATE_DBG(st4)
  );

  latch_write_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .NLAT(3)) dut3 (
    .CLK(CLK), .R(R), .REQ(REQ), .ADDR(ADDR), .WDATA(WDATA),
    .GNT(gnt3), .ACK(ack3), .ERR(err3), .BUSY(busy3), .D(d3), .EN(en3),
    .STATE_DBG(st3)
  );

  // ---------------- latch bank models ----------------
  logic [WIDTH-1:0] q4 [4];
  logic [WIDTH-1:0] q3 [3];

  always_latch begin
    for (int i = 0; i < 4; i++) begin
      if (!R) q4[i] = '0;
      else if (en4[i]) q4[i] = d4;
    end
  end

  always_latch begin
    for (int i = 0; i < 3; i++) begin
      if (!R) q3[i] = '0;
      else if (en3[i]) q3[i] = d3;
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    ADDR[i*AW +: AW]        = a;
    WDATA[i*WIDTH +: WIDTH] = d;
    REQ[i]                  = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    R = 1'b0;
    REQ = 4'b1111;
    ADDR = '0;
    WDATA = '0;
    repeat (3) tick();
    n_checks++; if (en4 !== 4'b0000) begin n_fail++; $display("FAIL reset_en got=%b exp=0000", en4); end
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt4); end
    n_checks++; if (ack4 !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack4); end
    n_checks++; if (d4 !== 8'h00) begin n_fail++; $display("FAIL reset_d got=%h exp=00", d4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    n_checks++; if (st4 !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", st4, IDLE); end
    R = 1'b1;
    tick();
    n_checks++; if (gnt4 !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt4); end
    n_checks++; if (busy4 !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got=%b exp=1", busy4); end
    REQ = '0;
    repeat (3) tick();
  endtask

  task automatic test_single_write();
    REQ = '0;
    set_req(2, 2'd1, 8'hA5);
    tick();
    REQ = '0;
    n_checks++; if (d4 !== 8'hA5) begin n_fail++; $display("FAIL single_setup_d got=%h exp=a5", d4); end
    n_checks++; if (gnt4 !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", gnt4); end
    n_checks++; if (en4 !== 4'b0000) begin n_fail++; $display("FAIL single_setup_en got=%b exp=0000", en4); end
    tick();
    n_checks++; if (en4 !== 4'b0010) begin n_fail++; $display("FAIL single_pulse_en got=%b exp=0010", en4); end
    n_checks++; if (ack4 !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_ack got=%b exp=0000", ack4); end
    tick();
    n_checks++; if (en4 !== 4'b0000) begin n_fail++; $display("FAIL single_hold_en got=%b exp=0000", en4); end
    n_checks++; if (ack4 !== 4'b0100) begin n_fail++; $display("FAIL single_hold_ack got=%b exp=0100", ack4); end
    n_checks++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL single_hold_err got=%b exp=0", err4); end
    n_checks++; if (d4 !== 8'hA5) begin n_fail++; $display("FAIL single_hold_d got=%h exp=a5", d4); end
    WDATA[2*WIDTH +: WIDTH] = 8'h00;
    tick();
    n_checks++; if (q4[1] !== 8'hA5) begin n_fail++; $display("FAIL single_latch_q1 got=%h exp=a5", q4[1]); end
    n_checks++; if (ack4 !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ack got=%b exp=0000", ack4); end
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("FAIL single_idle_gnt got=%b exp=0000", gnt4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL single_idle_busy got=%b exp=0", busy4); end
    n_checks++; if (d4 !== 8'hA5) begin n_fail++; $display("FAIL single_idle_d_retained got=%h exp=a5", d4); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt;
    int         last_ack;
    // Restart from a fresh reset so the pointer is back at requester 0.
    R = 1'b0;
    tick();
    R = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i), 8'h10 + 8'(i));
    last_ack = 0;
    for (int t = 0; t < 5; t++) begin
      exp_gnt = 4'b0001 << (t % 4);
      tick();
      n_checks++; if (gnt4 !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d] got=%b exp=%b", t, gnt4, exp_gnt); end
      tick();
      tick();
      n_checks++; if (ack4 !== exp_gnt) begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp=%b", t, ack4, exp_gnt); end
      if (t > 0) begin
        n_checks++; if (cyc - last_ack !== 4) begin n_fail++; $display("FAIL rr_ack_spacing[%0d] got=%0d exp=4", t, cyc - last_ack); end
      end
      last_ack = cyc;
      tick();
    end
    REQ = '0;
    n_checks++; if (q4[3] !== 8'h13) begin n_fail++; $display("FAIL rr_latch_q3 got=%h exp=13", q4[3]); end
  endtask

  task automatic test_input_change();
    REQ = '0;
    set_req(1, 2'd3, 8'h3C);
    tick();
    n_checks++; if (gnt4 !== 4'b0010) begin n_fail++; $display("FAIL chg_gnt got=%b exp=0010", gnt4); end
    WDATA[1*WIDTH +: WIDTH] = 8'hFF;
    REQ = '0;
    tick();
    n_checks++; if (en4 !== 4'b1000) begin n_fail++; $display("FAIL chg_pulse_en got=%b exp=1000", en4); end
    n_checks++; if (d4 !== 8'h3C) begin n_fail++; $display("FAIL chg_d got=%h exp=3c", d4); end
    tick();
    n_checks++; if (ack4 !== 4'b0010) begin n_fail++; $display("FAIL chg_ack got=%b exp=0010", ack4); end
    tick();
    n_checks++; if (q4[3] !== 8'h3C) begin n_fail++; $display("FAIL chg_latch_q3 got=%h exp=3c", q4[3]); end
  endtask

  task automatic test_out_of_range();
    logic [WIDTH-1:0] snap [3];
    for (int i = 0; i < 3; i++) snap[i] = q3[i];
    REQ = '0;
    set_req(0, 2'd3, 8'h77);
    tick();
    REQ = '0;
    n_checks++; if (gnt3 !== 4'b0001) begin n_fail++; $display("FAIL oor_gnt got=%b exp=0001", gnt3); end
    n_checks++; if (en3 !== 3'b000) begin n_fail++; $display("FAIL oor_setup_en got=%b exp=000", en3); end
    tick();
    n_checks++; if (en3 !== 3'b000) begin n_fail++; $display("FAIL oor_pulse_en got=%b exp=000", en3); end
    n_checks++; if (en4 !== 4'b1000) begin n_fail++; $display("FAIL oor_inrange_en4 got=%b exp=1000", en4); end
    tick();
    n_checks++; if (ack3 !== 4'b0001) begin n_fail++; $display("FAIL oor_ack got=%b exp=0001", ack3); end
    n_checks++; if (err3 !== 1'b1) begin n_fail++; $display("FAIL oor_err got=%b exp=1", err3); end
    n_checks++; if (err4 !== 1'b0) begin n_fail++; $display("FAIL oor_err_nlat4 got=%b exp=0", err4); end
    n_checks++; if (en3 !== 3'b000) begin n_fail++; $display("FAIL oor_hold_en got=%b exp=000", en3); end
    tick();
    n_checks++; if (err3 !== 1'b0) begin n_fail++; $display("FAIL oor_err_clear got=%b exp=0", err3); end
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (q3[i] !== snap[i]) begin n_fail++; $display("FAIL oor_latch_q[%0d] got=%h exp=%h", i, q3[i], snap[i]); end
    end
  endtask

  task automatic test_reset_mid();
    REQ = '0;
    set_req(2, 2'd2, 8'h5A);
    tick();
    REQ = '0;
    tick();
    n_checks++; if (en4 !== 4'b0100) begin n_fail++; $display("FAIL mid_pulse_en got=%b exp=0100", en4); end
    #2;
    R = 1'b0;
    #1;
    n_checks++; if (en4 !== 4'b0000) begin n_fail++; $display("FAIL mid_async_en got=%b exp=0000", en4); end
    n_checks++; if (gnt4 !== 4'b0000) begin n_fail++; $display("FAIL mid_async_gnt got=%b exp=0000", gnt4); end
    n_checks++; if (busy4 !== 1'b0) begin n_fail++; $display("FAIL mid_async_busy got=%b exp=0", busy4); end
    tick();
    n_checks++; if (ack4 !== 4'b0000) begin n_fail++; $display("FAIL mid_no_ack got=%b exp=0000", ack4); end
    R = 1'b1;
    tick();
    n_checks++; if (st4 !== IDLE) begin n_fail++; $display("FAIL mid_state got=%0d exp=%0d", st4, IDLE); end
    n_checks++; if (ack4 !== 4'b0000) begin n_fail++; $display("FAIL mid_no_ack_after got=%b exp=0000", ack4); end
    REQ = 4'b1111;
    tick();
    n_checks++; if (gnt4 !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr_zero got=%b exp=0001", gnt4); end
    REQ = '0;
    repeat (3) tick();
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_input_change();
    test_out_of_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
